multicycle_ctrl: RTL and testbench

- Control FSM for the multicycle 32-bit datapath.
- Drives the load enables of the datapath's 32-bit load-enable registers: PC, IR, A/B, ALUOut, MDR.
- Also drives register-file write, memory strobes and mux selects, and handshakes with a variable-latency memory through mem_ready.
- Counts retired instructions and stops the machine on HALT.

---
 rtl/multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle 32-bit datapath: sequences fetch/decode/execute/memory/writeback,
// handshakes with variable-latency memory via mem_ready and counts retired instructions.
module multicycle_ctrl #(
    parameter logic [5:0] OP_R    = 6'h20,
    parameter logic [5:0] OP_ALUI = 6'h38,
    parameter logic [5:0] OP_LW   = 6'h0F,
    parameter logic [5:0] OP_SW   = 6'h1F,
    parameter logic [5:0] OP_BEQ  = 6'h00,
    parameter logic [5:0] OP_HALT = 6'h3F
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_ld,
    output logic        pc_sel,
    output logic        ir_ld,
    output logic        ab_ld,
    output logic        alu_out_ld,
    output logic        mdr_ld,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        alu_src_imm,
    output logic [1:0]  alu_op,
    output logic        mem_rd,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        halted,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {S_IF, S_DEC, S_EXE, S_MEM, S_WB, S_HALTED} state_t;

    state_t state, next_state;
    logic   retire;
    logic   known_op;

    assign known_op = opcode inside {OP_R, OP_ALUI, OP_LW, OP_SW, OP_BEQ};

    // Mealy decode; reset gates every output so an in-flight access is dropped in the same cycle.
    always_comb begin
        pc_ld        = 1'b0;
        pc_sel       = 1'b0;
        ir_ld        = 1'b0;
        ab_ld        = 1'b0;
        alu_out_ld   = 1'b0;
        mdr_ld       = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;
        alu_src_imm  = 1'b0;
        alu_op       = 2'd0;
        mem_rd       = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        halted       = 1'b0;
        retire       = 1'b0;
        next_state   = state;
        if (!reset) begin
            case (state)
                S_IF: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_ld      = 1'b1;
                        pc_ld      = 1'b1;
                        next_state = S_DEC;
                    end
                end
                S_DEC: begin
                    ab_ld = 1'b1;
                    if (opcode == OP_HALT) begin
                        next_state = S_HALTED;
                    end else if (known_op) begin
                        next_state = S_EXE;
                    end else begin
                        next_state = S_IF;
                        retire     = 1'b1;
                    end
                end
                S_EXE: begin
                    alu_out_ld = 1'b1;
                    next_state = S_IF;
                    case (opcode)
                        OP_R: begin
                            alu_op     = 2'd1;
                            next_state = S_WB;
                        end
                        OP_ALUI: begin
                            alu_src_imm = 1'b1;
                            next_state  = S_WB;
                        end
                        OP_LW, OP_SW: begin
                            alu_src_imm = 1'b1;
                            next_state  = S_MEM;
                        end
                        OP_BEQ: begin
                            alu_op = 2'd2;
                            pc_ld  = zero;
                            pc_sel = zero;
                            retire = 1'b1;
                        end
                        default: next_state = S_IF;
                    endcase
                end
                S_MEM: begin
                    mem_addr_sel = 1'b1;
                    if (opcode == OP_LW) begin
                        mem_rd = 1'b1;
                        if (mem_ready) begin
                            mdr_ld     = 1'b1;
                            next_state = S_WB;
                        end
                    end else begin
                        mem_we = 1'b1;
                        if (mem_ready) begin
                            next_state = S_IF;
                            retire     = 1'b1;
                        end
                    end
                end
                S_WB: begin
                    rf_we      = 1'b1;
                    wb_sel     = (opcode == OP_LW);
                    next_state = S_IF;
                    retire     = 1'b1;
                end
                S_HALTED: halted = 1'b1;
                default:  next_state = S_IF;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= S_IF;
            instr_cnt <= '0;
        end else begin
            state <= next_state;
            if (retire)
                instr_cnt <= instr_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle timelines derived from opcode,
// wait counts and branch outcome are replayed against the DUT cycle by cycle.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'h20;
    localparam logic [5:0] OP_ALUI = 6'h38;
    localparam logic [5:0] OP_LW   = 6'h0F;
    localparam logic [5:0] OP_SW   = 6'h1F;
    localparam logic [5:0] OP_BEQ  = 6'h00;
    localparam logic [5:0] OP_HALT = 6'h3F;

    // Output vector bit positions: {pc_ld,pc_sel,ir_ld,ab_ld,alu_out_ld,mdr_ld,rf_we,wb_sel,imm,alu_op,mem_rd,mem_we,addr_sel,halted}
    localparam logic [14:0] B_PC_LD  = 15'h4000;
    localparam logic [14:0] B_PC_SEL = 15'h2000;
    localparam logic [14:0] B_IR_LD  = 15'h1000;
    localparam logic [14:0] B_AB_LD  = 15'h0800;
    localparam logic [14:0] B_ALU_LD = 15'h0400;
    localparam logic [14:0] B_MDR_LD = 15'h0200;
    localparam logic [14:0] B_RF_WE  = 15'h0100;
    localparam logic [14:0] B_WB_SEL = 15'h0080;
    localparam logic [14:0] B_IMM    = 15'h0040;
    localparam logic [14:0] B_OP_FN  = 15'h0010;
    localparam logic [14:0] B_OP_SUB = 15'h0020;
    localparam logic [14:0] B_MEM_RD = 15'h0008;
    localparam logic [14:0] B_MEM_WE = 15'h0004;
    localparam logic [14:0] B_ADDR   = 15'h0002;
    localparam logic [14:0] B_HALTED = 15'h0001;

    typedef struct packed {
        logic [5:0]  op;
        logic        rdy;
        logic        z;
        logic        ret;
        logic [14:0] exp;
    } cyc_t;

    logic        CLK = 1'b0;
    logic        reset, zero, mem_ready;
    logic [5:0]  opcode;
    logic        pc_ld, pc_sel, ir_ld, ab_ld, alu_out_ld, mdr_ld, rf_we, wb_sel, alu_src_imm;
    logic [1:0]  alu_op;
    logic        mem_rd, mem_we, mem_addr_sel, halted;
    logic [31:0] instr_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt  = '0;
    cyc_t        sched[$];

    always #5 CLK = ~CLK;

    multicycle_ctrl #(
        .OP_R(OP_R), .OP_ALUI(OP_ALUI), .OP_LW(OP_LW),
        .OP_SW(OP_SW), .OP_BEQ(OP_BEQ), .OP_HALT(OP_HALT)
    ) dut (
        .CLK(CLK), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_ld(pc_ld), .pc_sel(pc_sel), .ir_ld(ir_ld), .ab_ld(ab_ld), .alu_out_ld(alu_out_ld),
        .mdr_ld(mdr_ld), .rf_we(rf_we), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm),
        .alu_op(alu_op), .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .halted(halted), .instr_cnt(instr_cnt)
    );

    function automatic cyc_t mk(input logic [5:0] op, input logic rdy, input logic z,
                                input logic ret, input logic [14:0] exp);
        cyc_t c;
        c.op = op; c.rdy = rdy; c.z = z; c.ret = ret; c.exp = exp;
        return c;
    endfunction

    // Reference timeline for one instruction: fetch waits, decode, then the opcode's own path.
    function automatic void add_instr(input logic [5:0] op, input logic z,
                                      input int unsigned wif, input int unsigned wmem);
        logic is_nop;
        is_nop = !(op inside {OP_R, OP_ALUI, OP_LW, OP_SW, OP_BEQ, OP_HALT});
        for (int unsigned i = 0; i < wif; i++)
            sched.push_back(mk(6'($urandom), 1'b0, 1'($urandom), 1'b0, B_MEM_RD));
        sched.push_back(mk(6'($urandom), 1'b1, 1'($urandom), 1'b0, B_MEM_RD | B_IR_LD | B_PC_LD));
        sched.push_back(mk(op, 1'($urandom), 1'($urandom), is_nop, B_AB_LD));
        if (op == OP_R || op == OP_ALUI) begin
            sched.push_back(mk(op, 1'($urandom), 1'($urandom), 1'b0,
                               B_ALU_LD | ((op == OP_R) ? B_OP_FN : B_IMM)));
            sched.push_back(mk(op, 1'($urandom), 1'($urandom), 1'b1, B_RF_WE));
        end else if (op == OP_LW) begin
            sched.push_back(mk(op, 1'($urandom), 1'($urandom), 1'b0, B_ALU_LD | B_IMM));
            for (int unsigned i = 0; i < wmem; i++)
                sched.push_back(mk(op, 1'b0, 1'($urandom), 1'b0, B_MEM_RD | B_ADDR));
            sched.push_back(mk(op, 1'b1, 1'($urandom), 1'b0, B_MEM_RD | B_ADDR | B_MDR_LD));
            sched.push_back(mk(op, 1'($urandom), 1'($urandom), 1'b1, B_RF_WE | B_WB_SEL));
        end else if (op == OP_SW) begin
            sched.push_back(mk(op, 1'($urandom), 1'($urandom), 1'b0, B_ALU_LD | B_IMM));
            for (int unsigned i = 0; i < wmem; i++)
                sched.push_back(mk(op, 1'b0, 1'($urandom), 1'b0, B_MEM_WE | B_ADDR));
            sched.push_back(mk(op, 1'b1, 1'($urandom), 1'b1, B_MEM_WE | B_ADDR));
        end else if (op == OP_BEQ) begin
            sched.push_back(mk(op, 1'($urandom), z, 1'b1,
                               B_ALU_LD | B_OP_SUB | (z ? (B_PC_LD | B_PC_SEL) : 15'h0)));
        end
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] o;
        case ($urandom_range(0, 5))
            0: o = OP_R;
            1: o = OP_ALUI;
            2: o = OP_LW;
            3: o = OP_SW;
            4: o = OP_BEQ;
            default: begin
                do o = 6'($urandom);
                while (o inside {OP_R, OP_ALUI, OP_LW, OP_SW, OP_BEQ, OP_HALT});
            end
        endcase
        return o;
    endfunction

    // Drives one cycle's inputs just after the edge and samples outputs at the falling edge.
    task automatic play_one(input cyc_t c, output logic [14:0] act, output logic [31:0] cnt);
        opcode = c.op; mem_ready = c.rdy; zero = c.z;
        @(negedge CLK);
        act = {pc_ld, pc_sel, ir_ld, ab_ld, alu_out_ld, mdr_ld, rf_we, wb_sel,
               alu_src_imm, alu_op, mem_rd, mem_we, mem_addr_sel, halted};
        cnt = instr_cnt;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        logic [14:0] act;
        logic [31:0] cnt;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            play_one(mk(6'($urandom), 1'b1, 1'($urandom), 1'b0, 15'h0), act, cnt);
            checks++;
            if (act !== 15'h0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got=%h want=0000", i, act);
            end
        end
        checks++;
        if (instr_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%h want=00000000", instr_cnt);
        end
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_r_type();
        logic [14:0] act;
        logic [31:0] cnt;
        cyc_t c;
        add_instr(OP_R, 1'b0, 0, 0);
        while (sched.size() > 0) begin
            c = sched.pop_front();
            play_one(c, act, cnt);
            checks += 2;
            if (act !== c.exp) begin failures++; $display("FAIL r_type_out got=%h want=%h", act, c.exp); end
            if (cnt !== exp_cnt) begin failures++; $display("FAIL r_type_cnt got=%0d want=%0d", cnt, exp_cnt); end
            if (c.ret) exp_cnt++;
        end
    endtask

    task automatic test_lw_wait();
        logic [14:0] act;
        logic [31:0] cnt;
        cyc_t c;
        add_instr(OP_LW, 1'b0, 0, 3);
        checks++;
        if (sched.size() != 8) begin failures++; $display("FAIL lw_len got=%0d want=8", sched.size()); end
        while (sched.size() > 0) begin
            c = sched.pop_front();
            play_one(c, act, cnt);
            checks += 2;
            if (act !== c.exp) begin failures++; $display("FAIL lw_out got=%h want=%h", act, c.exp); end
            if (cnt !== exp_cnt) begin failures++; $display("FAIL lw_cnt got=%0d want=%0d", cnt, exp_cnt); end
            if (c.ret) exp_cnt++;
        end
    endtask

    task automatic test_beq();
        logic [14:0] act;
        logic [31:0] cnt;
        cyc_t c;
        add_instr(OP_BEQ, 1'b1, 0, 0);
        add_instr(OP_BEQ, 1'b0, 0, 0);
        while (sched.size() > 0) begin
            c = sched.pop_front();
            play_one(c, act, cnt);
            checks += 2;
            if (act !== c.exp) begin failures++; $display("FAIL beq_out got=%h want=%h", act, c.exp); end
            if (cnt !== exp_cnt) begin failures++; $display("FAIL beq_cnt got=%0d want=%0d", cnt, exp_cnt); end
            if (c.ret) exp_cnt++;
        end
    endtask

    task automatic test_random();
        logic [14:0] act;
        logic [31:0] cnt;
        cyc_t c;
        for (int i = 0; i < 40; i++)
            add_instr(rand_op(), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        while (sched.size() > 0) begin
            c = sched.pop_front();
            play_one(c, act, cnt);
            checks += 2;
            if (act !== c.exp) begin failures++; $display("FAIL rand_out op=%h got=%h want=%h", c.op, act, c.exp); end
            if (cnt !== exp_cnt) begin failures++; $display("FAIL rand_cnt got=%0d want=%0d", cnt, exp_cnt); end
            if (c.ret) exp_cnt++;
        end
    endtask

    task automatic test_sw_reset();
        logic [14:0] act;
        logic [31:0] cnt;
        cyc_t c;
        add_instr(OP_SW, 1'b0, 0, 3);
        // IF, DEC, EXE, first MEM wait; the second MEM wait is replaced by a reset cycle.
        for (int i = 0; i < 4; i++) begin
            c = sched.pop_front();
            play_one(c, act, cnt);
            checks += 2;
            if (act !== c.exp) begin failures++; $display("FAIL swrst_out got=%h want=%h", act, c.exp); end
            if (cnt !== exp_cnt) begin failures++; $display("FAIL swrst_cnt got=%0d want=%0d", cnt, exp_cnt); end
        end
        sched.delete();
        reset = 1'b1;
        play_one(mk(OP_SW, 1'b0, 1'b0, 1'b0, 15'h0), act, cnt);
        checks++;
        if (act !== 15'h0) begin failures++; $display("FAIL swrst_abort got=%h want=0000", act); end
        reset = 1'b0;
        exp_cnt = '0;
        play_one(mk(OP_SW, 1'b0, 1'b0, 1'b0, B_MEM_RD), act, cnt);
        checks += 2;
        if (act !== B_MEM_RD) begin failures++; $display("FAIL swrst_if got=%h want=%h", act, B_MEM_RD); end
        if (cnt !== 32'd0) begin failures++; $display("FAIL swrst_cnt0 got=%0d want=0", cnt); end
    endtask

    task automatic test_halt_wrap();
        logic [14:0] act;
        logic [31:0] cnt;
        cyc_t c;
        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        exp_cnt = '0;
        for (int i = 0; i < 5; i++)
            add_instr(rand_op(), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        add_instr(OP_HALT, 1'b0, 1, 0);
        for (int i = 0; i < 20; i++)
            sched.push_back(mk(6'($urandom), 1'($urandom), 1'($urandom), 1'b0, B_HALTED));
        while (sched.size() > 0) begin
            c = sched.pop_front();
            play_one(c, act, cnt);
            checks += 2;
            if (act !== c.exp) begin failures++; $display("FAIL halt_out got=%h want=%h", act, c.exp); end
            if (cnt !== exp_cnt) begin failures++; $display("FAIL halt_cnt got=%0d want=%0d", cnt, exp_cnt); end
            if (c.ret) exp_cnt++;
        end
        checks++;
        if (instr_cnt !== 32'd5) begin failures++; $display("FAIL halt_total got=%0d want=5", instr_cnt); end

        reset = 1'b1;
        @(posedge CLK); #1;
        reset = 1'b0;
        force dut.instr_cnt = 32'hFFFF_FFFE;
        release dut.instr_cnt;
        exp_cnt = 32'hFFFF_FFFE;
        add_instr(6'h01, 1'b0, 0, 0);
        add_instr(6'h02, 1'b0, 0, 0);
        add_instr(OP_R, 1'b0, 0, 0);
        while (sched.size() > 0) begin
            c = sched.pop_front();
            play_one(c, act, cnt);
            checks += 2;
            if (act !== c.exp) begin failures++; $display("FAIL wrap_out got=%h want=%h", act, c.exp); end
            if (cnt !== exp_cnt) begin failures++; $display("FAIL wrap_cnt got=%h want=%h", cnt, exp_cnt); end
            if (c.ret) exp_cnt++;
        end
        @(negedge CLK);
        checks++;
        if (instr_cnt !== 32'd1) begin failures++; $display("FAIL wrap_final got=%h want=00000001", instr_cnt); end
    endtask

    initial begin
        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        test_reset();
        test_r_type();
        test_lw_wait();
        test_beq();
        test_random();
        test_sw_reset();
        test_halt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
